// File: rtl/functional_unit_if.sv
// Issue/register/write-back bundle between the reservation station side and functional_unit.
interface functional_unit_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned TAG_W  = 3
);
  logic [DATA_W-1:0] inst;
  logic              instEnable;
  logic [TAG_W-1:0]  instructionCodeIn;
  logic [DATA_W-1:0] Reg1;
  logic [DATA_W-1:0] Reg2;
  logic [DATA_W-1:0] Reg3;
  logic [DATA_W-1:0] Reg4;
  logic [DATA_W-1:0] Reg5;
  logic [DATA_W-1:0] Reg6;
  logic [TAG_W-1:0]  instructionCodeOut;
  logic              d;
  logic [DATA_W-1:0] dInst;
  logic [DATA_W-1:0] dout;
  logic              available;

  modport master (
    output inst, instEnable, instructionCodeIn,
    output Reg1, Reg2, Reg3, Reg4, Reg5, Reg6,
    input  instructionCodeOut, d, dInst, dout, available
  );

  modport slave (
    input  inst, instEnable, instructionCodeIn,
    input  Reg1, Reg2, Reg3, Reg4, Reg5, Reg6,
    output instructionCodeOut, d, dInst, dout, available
  );
endinterface

// File: rtl/functional_unit.sv
// Multi-cycle integer execution unit with built-in operand mux and one-cycle CDB write-back.
// FU_IMM_SIGN_EXT_EN: when defined, the ADDI/SUBI immediate is sign-extended instead of zero-extended.
module functional_unit #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned TAG_W   = 3,
  parameter int unsigned ALU_LAT = 2,
  parameter int unsigned MUL_LAT = 3
) (
  input  logic              Clock,
  input  logic              Reset,
  functional_unit_if.slave  bus
);

  localparam int unsigned MAX_LAT = (MUL_LAT > ALU_LAT) ? MUL_LAT : ALU_LAT;
  localparam int unsigned CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_ADDI = 4'b0010;
  localparam logic [3:0] OP_SUBI = 4'b0011;
  localparam logic [3:0] OP_MUL  = 4'b0100;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t             state, state_next;
  logic [CNT_W-1:0]   cnt, cnt_next;
  logic               issue_c, done_c;

  logic [DATA_W-1:0]  regs_c [8];
  logic [3:0]         opcode_c;
  logic [DATA_W-1:0]  imm_c, a_c, b_c, result_c;
  logic [CNT_W-1:0]   lat_c;

  logic [DATA_W-1:0]  res_q, inst_q, dout_q, dinst_q;
  logic [TAG_W-1:0]   tag_q, tag_out_q;
  logic               d_q, available_q;

  // Select 0 and 7 read as zero.
  always_comb begin
    regs_c[0] = '0;
    regs_c[1] = bus.Reg1;
    regs_c[2] = bus.Reg2;
    regs_c[3] = bus.Reg3;
    regs_c[4] = bus.Reg4;
    regs_c[5] = bus.Reg5;
    regs_c[6] = bus.Reg6;
    regs_c[7] = '0;
  end

`ifdef FU_IMM_SIGN_EXT_EN
  assign imm_c = {{(DATA_W-6){bus.inst[15]}}, bus.inst[15:10]};
`else
  assign imm_c = DATA_W'(bus.inst[15:10]);
`endif

  assign opcode_c = bus.inst[3:0];
  assign a_c      = regs_c[bus.inst[9:7]];
  assign b_c      = (opcode_c == OP_ADDI || opcode_c == OP_SUBI) ? imm_c : regs_c[bus.inst[6:4]];
  assign lat_c    = (opcode_c == OP_MUL) ? CNT_W'(MUL_LAT - 1) : CNT_W'(ALU_LAT - 1);
  assign issue_c  = available_q & bus.instEnable;

  // Result is computed from the operands present at the issue edge.
  always_comb begin
    result_c = '0;
    case (opcode_c)
      OP_ADD, OP_ADDI: result_c = a_c + b_c;
      OP_SUB, OP_SUBI: result_c = a_c - b_c;
      OP_MUL:          result_c = a_c * b_c;
      default:         result_c = '0;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // cnt holds the number of busy edges remaining before completion.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    done_c     = 1'b0;
    case (state)
      IDLE: begin
        if (issue_c) begin
          state_next = BUSY;
          cnt_next   = lat_c;
        end
      end
      BUSY: begin
        if (cnt == '0) begin
          state_next = IDLE;
          done_c     = 1'b1;
        end else begin
          cnt_next = cnt - CNT_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      res_q       <= '0;
      inst_q      <= '0;
      tag_q       <= '0;
      d_q         <= 1'b0;
      dout_q      <= '0;
      dinst_q     <= '0;
      tag_out_q   <= '0;
      available_q <= 1'b1;
    end else begin
      d_q         <= done_c;
      available_q <= (state_next == IDLE);
      if (issue_c) begin
        res_q  <= result_c;
        inst_q <= bus.inst;
        tag_q  <= bus.instructionCodeIn;
      end
      if (done_c) begin
        dout_q    <= res_q;
        dinst_q   <= inst_q;
        tag_out_q <= tag_q;
      end
    end
  end

  assign bus.d                  = d_q;
  assign bus.dout               = dout_q;
  assign bus.dInst              = dinst_q;
  assign bus.instructionCodeOut = tag_out_q;
  assign bus.available          = available_q;

endmodule

// File: tb/tb_functional_unit.sv
// Scoreboard bench for functional_unit: driver pushes model results, negedge monitor pops on d.
module tb_functional_unit;

  localparam int unsigned ALU_LAT = 2;
  localparam int unsigned MUL_LAT = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  functional_unit_if #(.DATA_W(16), .TAG_W(3)) bus ();

  functional_unit #(
    .DATA_W(16), .TAG_W(3), .ALU_LAT(ALU_LAT), .MUL_LAT(MUL_LAT)
  ) dut (
    .Clock(clk),
    .Reset(rst),
    .bus  (bus)
  );

  typedef struct {
    logic [15:0] res;
    logic [15:0] inst;
    logic [2:0]  tag;
    int          done_cyc;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [15:0] regs [8];

  assign bus.Reg1 = regs[1];
  assign bus.Reg2 = regs[2];
  assign bus.Reg3 = regs[3];
  assign bus.Reg4 = regs[4];
  assign bus.Reg5 = regs[5];
  assign bus.Reg6 = regs[6];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: architectural meaning of each opcode in plain integer arithmetic.
  function automatic logic [15:0] model(input logic [15:0] ins, input logic [15:0] r [8]);
    longint a, b, imm, x;
    a   = longint'(r[ins[9:7]]);
    b   = longint'(r[ins[6:4]]);
    imm = longint'(ins[15:10]);
`ifdef FU_IMM_SIGN_EXT_EN
    if (ins[15]) imm = imm - 64;
`endif
    case (ins[3:0])
      4'd0:    x = a + b;
      4'd1:    x = a - b;
      4'd2:    x = a + imm;
      4'd3:    x = a - imm;
      4'd4:    x = a * b;
      default: x = 0;
    endcase
    return 16'(x);
  endfunction

  // Called at a negedge; issue lands on the next posedge.
  task automatic issue(input logic [15:0] ins, input logic [2:0] tag, input bit track);
    int   n;
    exp_t e;
    n = 0;
    while (bus.available !== 1'b1) begin
      @(negedge clk);
      n++;
      if (n > 50) begin
        checks++;
        errors++;
        $display("FAIL issue_wait: available stuck at %0b, required 1", bus.available);
        return;
      end
    end
    bus.inst              = ins;
    bus.instructionCodeIn = tag;
    bus.instEnable        = 1'b1;
    e.res  = model(ins, regs);
    e.inst = ins;
    e.tag  = tag;
    @(negedge clk);
    bus.instEnable = 1'b0;
    e.done_cyc = cyc + int'((ins[3:0] == 4'd4) ? MUL_LAT : ALU_LAT);
    if (track) sb.push_back(e);
    check("accept_available", 32'(bus.available), 32'd0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain", 32'(sb.size()), 32'd0);
  endtask

  // Monitor: every d pulse must match the oldest outstanding issue.
  always @(negedge clk) begin
    if (rst !== 1'b1 && bus.d === 1'b1) begin
      if (sb.size() == 0) begin
        check("spurious_d", 32'(bus.d), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("dout",    32'(bus.dout), 32'(e.res));
        check("dInst",   32'(bus.dInst), 32'(e.inst));
        check("tag",     32'(bus.instructionCodeOut), 32'(e.tag));
        check("latency", 32'(cyc), 32'(e.done_cyc));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] ins;
    logic [3:0]  op;
    for (int i = 0; i < 8; i++) regs[i] = 16'h0;
    rst                   = 1'b1;
    bus.inst              = 16'h0;
    bus.instEnable        = 1'b0;
    bus.instructionCodeIn = 3'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_d",     32'(bus.d), 32'd0);
    check("rst_dout",  32'(bus.dout), 32'd0);
    check("rst_dInst", 32'(bus.dInst), 32'd0);
    check("rst_tag",   32'(bus.instructionCodeOut), 32'd0);
    check("rst_avail", 32'(bus.available), 32'd1);

    // Reset mid-MUL aborts without a done pulse.
    regs[1] = 16'd300; regs[2] = 16'd300;
    issue(16'h0CA4, 3'd5, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_d",     32'(bus.d), 32'd0);
    check("abort_avail", 32'(bus.available), 32'd1);
    repeat (4) @(negedge clk);
    check("abort_idle_avail", 32'(bus.available), 32'd1);

    // Directed operations.
    regs[1] = 16'd5; regs[2] = 16'd7;
    issue(16'h0CA0, 3'd3, 1'b1);
    drain();
    issue(16'h0CA1, 3'd1, 1'b1);
    drain();

    regs[1] = 16'd300; regs[2] = 16'd300;
    issue(16'h0CA4, 3'd2, 1'b1);
    bus.inst = 16'h0CA0; bus.instructionCodeIn = 3'd6; bus.instEnable = 1'b1;
    regs[1] = 16'd999;
    @(negedge clk);
    bus.instEnable = 1'b0;
    check("busy_avail", 32'(bus.available), 32'd0);
    regs[1] = 16'd5; regs[2] = 16'd7;
    issue(16'h0CA0, 3'd4, 1'b1);
    drain();

    regs[1] = 16'd1;
    issue(16'hFCC2, 3'd7, 1'b1);
    drain();

    for (int i = 1; i < 7; i++) regs[i] = 16'hABCD + 16'(i);
    issue(16'h0C70, 3'd0, 1'b1);
    regs[1] = 16'h1234;
    drain();

    // Randomized traffic with busy-time noise on instEnable and registers.
    for (int k = 0; k < 60; k++) begin
      for (int i = 1; i < 7; i++) regs[i] = 16'($urandom);
      op  = ($urandom_range(0, 5) == 5) ? 4'($urandom) : 4'($urandom_range(0, 4));
      ins = {12'($urandom), op};
      issue(ins, 3'($urandom), 1'b1);
      if ($urandom_range(0, 1) == 1) begin
        bus.inst = 16'($urandom);
        bus.instructionCodeIn = 3'($urandom);
        bus.instEnable = 1'b1;
        for (int i = 1; i < 7; i++) regs[i] = 16'($urandom);
        @(negedge clk);
        bus.instEnable = 1'b0;
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    drain();
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
